// File: rtl/mc_pkg.sv
// Shared types and defaults for the round-robin multi-channel memory controller.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mc_state_e;

    localparam int MC_DW = 16;
    localparam int MC_AW = 4;

    // Channel index width; a single-bit index is kept even for degenerate counts.
    function automatic int mc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after the pointer, wrapping.
module rr_arbiter
    import mc_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = mc_idx_w(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic           o_any,
    output logic [IW-1:0]  o_idx,
    output logic [NCH-1:0] o_onehot
);

    int w_c;

    // Scan from farthest to nearest offset so the closest requester is written last and wins.
    always_comb begin
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_c      = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_c      = (int'(i_ptr) + k) % NCH;
            o_any    = o_any | i_req[w_c];
            o_idx    = i_req[w_c] ? IW'(w_c) : o_idx;
            o_onehot = i_req[w_c] ? (NCH'(1'b1) << w_c) : o_onehot;
        end
    end

endmodule

// File: rtl/mem_ctrl_rr.sv
// Multi-channel memory controller: round-robin admission, one transaction at a time,
// shared storage array with per-channel grant and read-valid pulses.
module mem_ctrl_rr
    import mc_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = MC_DW,
    parameter int AW  = MC_AW
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdata,
    output logic              busy
);

    localparam int IW    = mc_idx_w(NCH);
    localparam int DEPTH = 2 ** AW;

    mc_state_e        r_state;
    mc_state_e        w_next;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;
    logic [NCH-1:0]   r_gnt;
    logic [NCH-1:0]   r_rvalid;
    logic             r_busy;
    logic [DW-1:0]    r_mem [DEPTH];

    logic             w_any;
    logic [IW-1:0]    w_win;
    logic [NCH-1:0]   w_oh;
    logic [NCH-1:0]   w_gnt_nxt;
    logic [NCH-1:0]   w_rvalid_nxt;
    logic             w_busy_nxt;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_idx    (w_win),
        .o_onehot (w_oh)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: writes return to IDLE after ACCESS, reads go through RESP.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = r_we ? IDLE : RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered without extra latency.
    always_comb begin
        w_gnt_nxt    = '0;
        w_rvalid_nxt = '0;
        w_busy_nxt   = 1'b0;
        case (w_next)
            ACCESS: begin
                w_gnt_nxt  = w_oh;
                w_busy_nxt = 1'b1;
            end
            RESP: begin
                w_rvalid_nxt = NCH'(1'b1) << r_win;
                w_busy_nxt   = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Winner latch, pointer advance and read capture; rdata holds until the next read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr   <= '0;
            r_win   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_we    <= we[w_win];
                        r_addr  <= addr[w_win*AW +: AW];
                        r_wdata <= wdata[w_win*DW +: DW];
                    end
                end
                ACCESS: begin
                    r_ptr <= (r_win == IW'(NCH - 1)) ? '0 : r_win + IW'(1);
                    if (!r_we) begin
                        r_rdata <= r_mem[r_addr];
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge CLK) begin
        if (r_state == ACCESS && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign busy   = r_busy;

endmodule
